cu_fsm: RTL

CU_FSM -- requirements
Module: cu_fsm

---
 rtl/cu_fsm_if.sv | 29 ++
 rtl/cu_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cu_fsm_if.sv
// rtl/cu_fsm_if.sv - control unit handshake bundle: decode fields in, datapath/memory enables out
interface cu_fsm_if;
  logic [6:0] cu_opcode;
  logic [2:0] func3;
  logic       intr;
  logic       csr_mie;
  logic       mem_rdy;
  logic       pc_write;
  logic       reg_write;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;
  logic [1:0] state;

  modport master (
    output cu_opcode, func3, intr, csr_mie, mem_rdy,
    input  pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
    input  csr_we, int_taken, mret_exec, state
  );

  modport slave (
    input  cu_opcode, func3, intr, csr_mie, mem_rdy,
    output pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
    output csr_we, int_taken, mret_exec, state
  );
endinterface

// File: rtl/cu_fsm.sv
// rtl/cu_fsm.sv - multicycle control unit: fetch/execute/writeback sequencing with interrupt entry
module cu_fsm (
  input  logic     clk,
  input  logic     rst_n,
  cu_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    INTR  = 2'd3
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t state;
  logic   pending;
  logic   intr_q;
  logic   intr_edge;
  logic   take_intr;
  state_t boundary_state;

  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_alu;
  logic is_system;

  // Opcode class decode shared by next-state and output logic
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_alu    = 1'b0;
    is_system = 1'b0;
    case (bus.cu_opcode)
      OPC_LOAD:   is_load   = 1'b1;
      OPC_STORE:  is_store  = 1'b1;
      OPC_BRANCH: is_branch = 1'b1;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM:
                  is_alu    = 1'b1;
      OPC_SYSTEM: is_system = 1'b1;
      default:    ;
    endcase
  end

  // Where an instruction goes when it completes; an edge arriving in the
  // completion cycle itself is honoured immediately rather than one instruction later
  always_comb begin
    intr_edge      = bus.intr & ~intr_q;
    take_intr      = (pending | intr_edge) & bus.csr_mie;
    boundary_state = take_intr ? INTR : FETCH;
  end

  // State register, interrupt edge detector and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pending <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      intr_q <= bus.intr;
      // the INTR cycle consumes the request, but a fresh edge in that cycle re-arms it
      if (state == INTR) begin
        pending <= intr_edge;
      end else begin
        pending <= pending | intr_edge;
      end
      case (state)
        FETCH: begin
          if (bus.mem_rdy) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_load) begin
            if (bus.mem_rdy) begin
              state <= WB;
            end
          end else if (is_store && !bus.mem_rdy) begin
            state <= EXEC;
          end else begin
            state <= boundary_state;
          end
        end
        WB:      state <= boundary_state;
        INTR:    state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Control outputs decoded from the current state; reset forces them all low without waiting for a clock
  always_comb begin
    bus.pc_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_rden1 = 1'b0;
    bus.mem_rden2 = 1'b0;
    bus.mem_we2   = 1'b0;
    bus.csr_we    = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;
    bus.state     = 2'd0;
    if (rst_n) begin
      bus.state = state;
      case (state)
        FETCH: bus.mem_rden1 = 1'b1;
        EXEC: begin
          if (is_load) begin
            bus.mem_rden2 = 1'b1;
          end else if (is_store) begin
            bus.mem_we2  = 1'b1;
            bus.pc_write = bus.mem_rdy;
          end else if (is_branch) begin
            bus.pc_write = 1'b1;
          end else if (is_alu) begin
            bus.pc_write  = 1'b1;
            bus.reg_write = 1'b1;
          end else if (is_system) begin
            bus.pc_write = 1'b1;
            if (bus.func3 == 3'd0) begin
              bus.mret_exec = 1'b1;
            end else begin
              bus.csr_we    = 1'b1;
              bus.reg_write = 1'b1;
            end
          end else begin
            bus.pc_write = 1'b1;
          end
        end
        WB: begin
          bus.pc_write  = 1'b1;
          bus.reg_write = 1'b1;
        end
        INTR: begin
          bus.pc_write  = 1'b1;
          bus.int_taken = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
